// File: rtl/regfile_32x32.sv
// 32 x DATA_WIDTH register file: one synchronous write port, two combinational
// read ports, register 0 reads as zero, optional same-cycle write-to-read bypass.
// The write target is selected by a 5-to-32 one-hot decoder.

module decoder_5_32 (
    input  logic [4:0]  sel,
    input  logic        en,
    output logic [31:0] out
);

    // One-hot decode of sel, all zero when disabled
    always_comb begin
        out = '0;
        if (en) begin
            out[sel] = 1'b1;
        end
    end

endmodule

module regfile_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 0
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [4:0]            ctrl_writeReg,
    input  logic [4:0]            ctrl_readRegA,
    input  logic [4:0]            ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    logic [31:0]           write_sel;
    logic                  write_sel0_unused;
    logic [DATA_WIDTH-1:0] regs [1:31];
    logic                  bypass_a;
    logic                  bypass_b;

    // Reset also blocks the decoder so a pending write can never land during reset
    decoder_5_32 u_decoder (
        .sel (ctrl_writeReg),
        .en  (ctrl_writeEnable & ~ctrl_reset),
        .out (write_sel)
    );

    // Register 0 has no storage; writes to it are simply dropped
    assign write_sel0_unused = write_sel[0];

    // Storage for registers 1..31: async clear, one-hot load on the rising edge
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (write_sel[i]) begin
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    // Forward write data only for a real, enabled write outside reset
    always_comb begin
        bypass_a = (BYPASS != 0) && ctrl_writeEnable && !ctrl_reset &&
                   (ctrl_writeReg != 5'd0) && (ctrl_readRegA == ctrl_writeReg);
        bypass_b = (BYPASS != 0) && ctrl_writeEnable && !ctrl_reset &&
                   (ctrl_writeReg != 5'd0) && (ctrl_readRegB == ctrl_writeReg);
    end

    // Read port A: zero for address 0, forwarded data when bypassing, else stored value
    always_comb begin
        data_readRegA = '0;
        if (ctrl_readRegA != 5'd0) begin
            if (bypass_a) begin
                data_readRegA = data_writeReg;
            end else begin
                data_readRegA = regs[ctrl_readRegA];
            end
        end
    end

    // Read port B: same selection as port A
    always_comb begin
        data_readRegB = '0;
        if (ctrl_readRegB != 5'd0) begin
            if (bypass_b) begin
                data_readRegB = data_writeReg;
            end else begin
                data_readRegB = regs[ctrl_readRegB];
            end
        end
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32: one instance without bypass, one with bypass,
// both driven from the same stimulus.

module tb_regfile_32x32;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    regfile_32x32 #(.DATA_WIDTH(32), .BYPASS(0)) dut_nobyp (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (rd_a0),
        .data_readRegB    (rd_b0)
    );

    regfile_32x32 #(.DATA_WIDTH(32), .BYPASS(1)) dut_byp (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (rd_a1),
        .data_readRegB    (rd_b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Synchronous write through both instances; model tracks stored contents
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = addr;
        data_writeReg    = data;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        if (addr != 5'd0) model[addr] = data;
    endtask

    // Sweep all addresses on both ports against the model (no write in flight)
    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            check($sformatf("%s nobyp A[%0d]", tag, i), rd_a0, model[i]);
            check($sformatf("%s nobyp B[%0d]", tag, 31 - i), rd_b0, model[31 - i]);
            check($sformatf("%s byp A[%0d]", tag, i), rd_a1, model[i]);
            check($sformatf("%s byp B[%0d]", tag, 31 - i), rd_b1, model[31 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        data_writeReg    = 32'h0;
        #2;
        sweep("rst_hold");
        @(negedge clock);
        ctrl_reset = 1'b0;

        // Dirty a register, then an async reset pulse must clear everything
        write_reg(5'd4, 32'h0BAD_F00D);
        ctrl_readRegA = 5'd4;
        #1;
        check("pre_pulse reg4", rd_a0, 32'h0BAD_F00D);
        #1;
        ctrl_reset = 1'b1;
        #1;
        check("async clear reg4", rd_a0, 32'h0000_0000);
        model[4] = 32'h0;
        sweep("rst_pulse");
        @(negedge clock);
        ctrl_reset = 1'b0;

        // Test 2: two writes on consecutive edges
        write_reg(5'd5, 32'hDEAD_BEEF);
        write_reg(5'd31, 32'h1234_5678);
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd31;
        #1;
        check("t2 A reg5", rd_a0, 32'hDEAD_BEEF);
        check("t2 B reg31", rd_b0, 32'h1234_5678);
        sweep("t2");

        // Test 3: writes to register 0 vanish, bypass included
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFF_FFFF;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        #1;
        check("t3 byp A reg0 same cycle", rd_a1, 32'h0);
        check("t3 byp B reg0 same cycle", rd_b1, 32'h0);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        check("t3 nobyp A reg0", rd_a0, 32'h0);
        check("t3 nobyp B reg0", rd_b0, 32'h0);
        check("t3 byp A reg0", rd_a1, 32'h0);
        check("t3 byp B reg0", rd_b1, 32'h0);

        // Test 4: same-cycle read of the register being written
        write_reg(5'd7, 32'h1111_1111);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h2222_2222;
        ctrl_readRegA    = 5'd7;
        ctrl_readRegB    = 5'd5;
        #1;
        check("t4 nobyp A old", rd_a0, 32'h1111_1111);
        check("t4 byp A fwd", rd_a1, 32'h2222_2222);
        check("t4 byp B other", rd_b1, 32'hDEAD_BEEF);
        ctrl_readRegB = 5'd7;
        #1;
        check("t4 nobyp B old", rd_b0, 32'h1111_1111);
        check("t4 byp B fwd", rd_b1, 32'h2222_2222);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        model[7] = 32'h2222_2222;
        #1;
        check("t4 nobyp A new", rd_a0, 32'h2222_2222);
        check("t4 byp A new", rd_a1, 32'h2222_2222);
        check("t4 nobyp B new", rd_b0, 32'h2222_2222);

        // Test 5: disabled writes change nothing
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'hCAFE_F00D;
        ctrl_readRegA    = 5'd9;
        ctrl_readRegB    = 5'd9;
        #1;
        check("t5 byp A no fwd", rd_a1, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check("t5 nobyp A reg9", rd_a0, 32'h0);
        check("t5 byp B reg9", rd_b1, 32'h0);
        sweep("t5");

        // Test 6: reset arriving while a write is pending wins
        write_reg(5'd3, 32'hA5A5_A5A5);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h7777_7777;
        ctrl_readRegA    = 5'd3;
        ctrl_readRegB    = 5'd5;
        #1;
        check("t6 nobyp A before rst", rd_a0, 32'hA5A5_A5A5);
        #1;
        ctrl_reset = 1'b1;
        #1;
        check("t6 nobyp A in rst", rd_a0, 32'h0);
        check("t6 byp A in rst", rd_a1, 32'h0);
        check("t6 nobyp B in rst", rd_b0, 32'h0);
        @(posedge clock);
        #1;
        check("t6 nobyp A rst edge", rd_a0, 32'h0);
        check("t6 byp A rst edge", rd_a1, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clock);
        ctrl_reset    = 1'b0;
        data_writeReg = 32'h5A5A_5A5A;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        model[3] = 32'h5A5A_5A5A;
        check("t6 nobyp A after release", rd_a0, 32'h5A5A_5A5A);
        check("t6 byp A after release", rd_a1, 32'h5A5A_5A5A);
        sweep("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
